// File: rtl/gate_sweep_checker.sv
// Exhaustive two-input gate block checker: steps a/b through 00,01,10,11,
// holds each vector SETTLE cycles, samples gate_in once and accumulates mismatches.
module gate_sweep_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] gate_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [6:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  // Bit order matches gate_in: {xnor, xor, nor, nand, not(a), or, and}
  function automatic logic [6:0] gate_expect(input logic a, input logic b);
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  endfunction

  state_t     state_q;
  logic [1:0] vec_q;
  logic [3:0] settle_q;
  logic       a_q, b_q, busy_q, done_q, pass_q;
  logic [2:0] err_q;
  logic [6:0] mask_q;

  logic [6:0] exp_s;
  logic [6:0] diff_s;
  logic       miss_s;
  logic [2:0] err_next_s;
  logic [1:0] vec_next_s;

  assign exp_s      = gate_expect(a_q, b_q);
  assign diff_s     = gate_in ^ exp_s;
  assign miss_s     = |diff_s;
  assign err_next_s = err_q + {2'b00, miss_s};
  assign vec_next_s = vec_q + 2'd1;

  // Sweep FSM with all outputs held in registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= 2'd0;
      settle_q <= 4'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 3'd0;
      mask_q   <= 7'h00;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          if (start) begin
            state_q  <= DRIVE;
            vec_q    <= 2'd0;
            settle_q <= 4'd0;
            busy_q   <= 1'b1;
            pass_q   <= 1'b0;
            err_q    <= 3'd0;
            mask_q   <= 7'h00;
          end else begin
            busy_q <= 1'b0;
          end
        end
        DRIVE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        SAMPLE: begin
          // At most four vectors can miss, so err_q never exceeds 4
          if (miss_s) begin
            err_q  <= err_next_s;
            mask_q <= mask_q | diff_s;
          end else begin
            err_q  <= err_q;
          end
          if (vec_q == 2'd3) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_next_s == 3'd0);
            a_q     <= 1'b0;
            b_q     <= 1'b0;
          end else begin
            state_q  <= DRIVE;
            vec_q    <= vec_next_s;
            settle_q <= 4'd0;
            a_q      <= vec_next_s[1];
            b_q      <= vec_next_s[0];
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          vec_q   <= 2'd0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          a_q     <= 1'b0;
          b_q     <= 1'b0;
        end
      endcase
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: SETTLE=1 and SETTLE=3 instances driven by a behavioural gate block
// with selectable faults; cycle numbers count from the edge that samples start.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n, start, start3;
  logic [6:0] gate_in, gate_in3;
  logic       a_out, b_out, busy, done, pass;
  logic [2:0] err_count;
  logic [6:0] fail_mask;
  logic       a3, b3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [6:0] mask3;
  int         fault_mode;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  gate_sweep_checker #(.SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_in(gate_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask)
  );

  gate_sweep_checker #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .gate_in(gate_in3),
    .a_out(a3), .b_out(b3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_mask(mask3)
  );

  // fault 1: and output stuck at 0; fault 2: not(a) output inverted
  function automatic logic [6:0] gate_model(input logic a, input logic b, input int fault);
    logic [6:0] g;
    g[0] = a && b;
    g[1] = a || b;
    g[2] = !a;
    g[3] = !(a && b);
    g[4] = !(a || b);
    g[5] = (a != b);
    g[6] = (a == b);
    if (fault == 1) g[0] = 1'b0;
    if (fault == 2) g[2] = ~g[2];
    return g;
  endfunction

  always_comb gate_in  = gate_model(a_out, b_out, fault_mode);
  always_comb gate_in3 = gate_model(a3, b3, 0);

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start3 = 1'b0; fault_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_out, b_out, busy, done, pass, err_count, fail_mask} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state got=%b/%b/%b/%b/%b/%0d/%h required all zero",
               a_out, b_out, busy, done, pass, err_count, fail_mask);
    end
    checks++;
    if ({a3, b3, busy3, done3, pass3, err3, mask3} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state3 busy=%b err=%0d required all zero", busy3, err3);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep(input int fault, input logic [2:0] exp_err,
                            input logic [6:0] exp_mask, input logic exp_pass);
    logic [1:0] v;
    fault_mode = fault;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== (c <= 9)) begin
        errors++;
        $display("FAIL sweep%0d_busy c=%0d got=%b required=%b", fault, c, busy, (c <= 9));
      end
      checks++;
      if (done !== (c == 9)) begin
        errors++;
        $display("FAIL sweep%0d_done c=%0d got=%b required=%b", fault, c, done, (c == 9));
      end
      if (c <= 8) begin
        v = 2'((c - 1) / 2);
        checks++;
        if ({a_out, b_out} !== v) begin
          errors++;
          $display("FAIL sweep%0d_vec c=%0d got=%b%b required=%b", fault, c, a_out, b_out, v);
        end
      end
      if (c >= 9) begin
        checks++;
        if ({pass, err_count, fail_mask} !== {exp_pass, exp_err, exp_mask}) begin
          errors++;
          $display("FAIL sweep%0d_result c=%0d got pass=%b err=%0d mask=%h required pass=%b err=%0d mask=%h",
                   fault, c, pass, err_count, fail_mask, exp_pass, exp_err, exp_mask);
        end
      end
    end
  endtask

  task automatic test_settle3();
    logic [1:0] v;
    @(negedge clk) start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (busy3 !== (c <= 17) || done3 !== (c == 17)) begin
        errors++;
        $display("FAIL settle3_ctrl c=%0d got busy=%b done=%b required busy=%b done=%b",
                 c, busy3, done3, (c <= 17), (c == 17));
      end
      if (c <= 16) begin
        v = 2'((c - 1) / 4);
        checks++;
        if ({a3, b3} !== v) begin
          errors++;
          $display("FAIL settle3_vec c=%0d got=%b%b required=%b", c, a3, b3, v);
        end
      end
      if (c == 17) begin
        checks++;
        if ({pass3, err3, mask3} !== {1'b1, 3'd0, 7'h00}) begin
          errors++;
          $display("FAIL settle3_result got pass=%b err=%0d mask=%h required 1/0/00",
                   pass3, err3, mask3);
        end
      end
      start3 = (c == 3 || c == 10 || c == 17);
    end
    start3 = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    fault_mode = 2;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 5) begin
        checks++;
        if (err_count !== 3'd2) begin
          errors++;
          $display("FAIL midrst_pre_err got=%0d required=2", err_count);
        end
        rst_n = 1'b0;
      end
      if (c == 6) begin
        checks++;
        if ({busy, a_out, b_out, err_count, fail_mask, pass} !== 14'd0) begin
          errors++;
          $display("FAIL midrst_cleared got busy=%b a=%b b=%b err=%0d mask=%h required zeros",
                   busy, a_out, b_out, err_count, fail_mask);
        end
        rst_n = 1'b1;
      end
      if (c >= 6) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL midrst_no_done c=%0d got done=%b busy=%b required 0/0", c, done, busy);
        end
      end
    end
    test_sweep(0, 3'd0, 7'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    int wait_cnt;
    fault_mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c <= 22) begin
        checks++;
        if (busy !== !(c == 10 || c == 20) || done !== (c == 9 || c == 19)) begin
          errors++;
          $display("FAIL b2b_ctrl c=%0d got busy=%b done=%b", c, busy, done);
        end
      end
      if (c == 9 || c == 10 || c == 19) begin
        checks++;
        if ({pass, err_count, fail_mask} !== {1'b0, 3'd1, 7'h01}) begin
          errors++;
          $display("FAIL b2b_result c=%0d got pass=%b err=%0d mask=%h required 0/1/01",
                   c, pass, err_count, fail_mask);
        end
      end
      if (c == 11) begin
        checks++;
        if ({pass, err_count, fail_mask} !== 11'd0) begin
          errors++;
          $display("FAIL b2b_clear got pass=%b err=%0d mask=%h required 0/0/00",
                   pass, err_count, fail_mask);
        end
      end
    end
    start = 1'b0;
    wait_cnt = 0;
    while (busy === 1'b1 && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got busy=%b required=0 after %0d cycles", busy, wait_cnt);
    end
    fault_mode = 0;
  endtask

  initial begin
    test_reset();
    test_sweep(0, 3'd0, 7'h00, 1'b1);
    test_sweep(1, 3'd1, 7'h01, 1'b0);
    test_sweep(2, 3'd4, 7'h04, 1'b0);
    test_settle3();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 Parameter: SETTLE, 1, cycles each vector is held on a_out/b_out before sampling; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  level-sampled request to begin a sweep.
REQ-005 Port: a_out  output  1  operand a driven to the two-input gate block.
REQ-006 Port: b_out  output  1  operand b driven to the two-input gate block.
REQ-007 Port: gate_in  input  7  gate block results: [0]=and, [1]=or, [2]=not(a), [3]=nand, [4]=nor, [5]=xor, [6]=xnor.
REQ-008 Port: busy  output  1  high while a sweep is in progress.
REQ-009 Port: done  output  1  one-cycle pulse at sweep completion.
REQ-010 Port: pass  output  1  high when the last completed sweep had zero mismatches.
REQ-011 Port: err_count  output  3  number of vectors (0..4) in the last sweep with at least one mismatching bit.
REQ-012 Port: fail_mask  output  7  sticky OR of mismatching gate_in bit positions over the sweep.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE. All outputs SHALL be registered.
REQ-014 IDLE: a_out=b_out=0, busy=0. start=1 SHALL move the FSM to DRIVE, set vector index to 0, and clear err_count, fail_mask and pass.
REQ-015 Vector order SHALL be 00, 01, 10, 11, with a_out=vec[1] and b_out=vec[0]. Operands SHALL be stable for the whole of DRIVE and SAMPLE.
REQ-016 DRIVE SHALL last exactly SETTLE cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle. In that cycle the block SHALL compare gate_in against expected = {~(a^b), a^b, ~(a|b), ~(a&b), ~a, a|b, a&b}, computed from the registered a_out/b_out.
REQ-018 On any mismatch in SAMPLE, err_count SHALL increment by 1, and fail_mask SHALL OR in (gate_in ^ expected).
REQ-019 SAMPLE with vec<3 SHALL increment vec and go to DRIVE. SAMPLE with vec==3 SHALL go to DONE.
REQ-020 DONE SHALL last one cycle: done=1, pass=(err_count==0), with err_count already including the final vector. The FSM then returns to IDLE.
REQ-021 busy SHALL be 1 in DRIVE, SAMPLE and DONE, and 0 in IDLE.
REQ-022 Timing: with start sampled at edge 0, done SHALL be high in cycle 4*(SETTLE+1)+1. For SETTLE=1 this is cycle 9.
REQ-023 start SHALL be ignored in DRIVE, SAMPLE and DONE. It SHALL be accepted only in IDLE.
REQ-024 start held high continuously SHALL cause back-to-back sweeps, with exactly one IDLE cycle between them.
REQ-025 pass, err_count and fail_mask SHALL hold their values from DONE until the next accepted start.
REQ-026 err_count SHALL saturate at 4 by construction; no wrap is possible.

Reset
REQ-027 A clock edge with rst_n=0 SHALL force IDLE, vec=0, and a_out=b_out=busy=done=pass=0, err_count=0, fail_mask=0.
REQ-028 Reset mid-sweep SHALL abort the sweep without a done pulse. rst_n has priority over start in the same cycle.

Verification
REQ-029 Correct gate model, SETTLE=1, pulse start -> busy high for cycles 1..9; a/b sequence 00,01,10,11 each held 2 cycles; done in cycle 9; pass=1, err_count=0, fail_mask=7'h00.
REQ-030 gate_in[0] stuck at 0 -> mismatch only at vector 11; err_count=1, fail_mask=7'h01, pass=0.
REQ-031 gate_in[2] inverted -> mismatch on all four vectors; err_count=4, fail_mask=7'h04, pass=0.
REQ-032 SETTLE=3, correct model -> each vector held 4 cycles, done in cycle 17; start pulses in cycles 3, 10 and 17 are ignored.
REQ-033 rst_n=0 in cycle 5 of a sweep -> next cycle busy=0, a_out=b_out=0, err_count=0; no done pulse; a fresh start then completes normally.
REQ-034 start held high for 25 cycles, SETTLE=1 -> two complete sweeps, with done in cycles 9 and 19; results from the first sweep are cleared in cycle 11.
